cache_req_sched: RTL and testbench

CACHE_REQ_SCHED -- requirements
Module: cache_req_sched

---
 rtl/cache_req_sched.sv | 163 ++++++++++++++++
 tb/tb_cache_req_sched.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/cache_req_sched.sv
// cache_req_sched
//   Two-requester round-robin scheduler in front of a single cache engine.
//   A legal request ('R' or 'W') is latched, presented to the engine for one
//   cycle (issue_valid) and then the engine is held busy for BUSY_CYCLES
//   cycles before the next request can be accepted. A request with any other
//   op code is accepted and dropped, and it bumps err_count.
//
// Ports
//   clk, reset          clock, asynchronous active-low reset
//   sched_en            gates acceptance of new requests only
//   rN_valid/addr/op    requester N request (held until rN_ready)
//   rN_ready            combinational accept strobe for requester N
//   cache_addr/op       latched request driven to the engine
//   issue_valid         one-cycle engine strobe
//   grant_id            owner of the current / last issued access
//   busy                scheduler is in ISSUE or WAIT
//   r0/r1_count         saturating per-requester issue counts
//   err_count           saturating count of illegal-op acceptances
module cache_req_sched #(
    parameter int ADDR_W      = 48,
    parameter int BUSY_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sched_en,
    input  logic              r0_valid,
    input  logic              r1_valid,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [7:0]        r0_op,
    input  logic [7:0]        r1_op,
    output logic              r0_ready,
    output logic              r1_ready,
    output logic [ADDR_W-1:0] cache_addr,
    output logic [7:0]        cache_op,
    output logic              issue_valid,
    output logic              grant_id,
    output logic              busy,
    output logic [15:0]       r0_count,
    output logic [15:0]       r1_count,
    output logic [15:0]       err_count
);

    localparam logic [3:0] BUSY_LD = 4'(BUSY_CYCLES);
    localparam logic [7:0] OP_RD   = 8'h52;
    localparam logic [7:0] OP_WR   = 8'h57;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              prio_q, prio_d;     // requester favoured on a tie
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        op_q, op_d;
    logic              gid_q, gid_d;
    logic [15:0]       r0c_q, r0c_d;
    logic [15:0]       r1c_q, r1c_d;
    logic [15:0]       errc_q, errc_d;

    logic              sel;
    logic              accept;
    logic [ADDR_W-1:0] sel_addr;
    logic [7:0]        sel_op;
    logic              sel_legal;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // A lone requester always wins; on a tie the pointer decides.
    assign sel       = (r0_valid && r1_valid) ? prio_q : !r0_valid;
    assign accept    = (state_q == S_IDLE) && sched_en && (r0_valid || r1_valid);
    assign sel_addr  = sel ? r1_addr : r0_addr;
    assign sel_op    = sel ? r1_op   : r0_op;
    assign sel_legal = (sel_op == OP_RD) || (sel_op == OP_WR);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prio_d  = prio_q;
        addr_d  = addr_q;
        op_d    = op_q;
        gid_d   = gid_q;
        r0c_d   = r0c_q;
        r1c_d   = r1c_q;
        errc_d  = errc_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    // Pointer moves on every acceptance, legal or not.
                    prio_d = !sel;
                    if (sel_legal) begin
                        addr_d  = sel_addr;
                        op_d    = sel_op;
                        gid_d   = sel;
                        state_d = S_ISSUE;
                    end else begin
                        errc_d = sat_inc(errc_q);
                    end
                end
            end
            S_ISSUE: begin
                if (gid_q) r1c_d = sat_inc(r1c_q);
                else       r0c_d = sat_inc(r0c_q);
                cnt_d   = BUSY_LD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // cnt_q counts remaining WAIT cycles including this one.
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            prio_q  <= 1'b0;
            addr_q  <= '0;
            op_q    <= 8'd0;
            gid_q   <= 1'b0;
            r0c_q   <= 16'd0;
            r1c_q   <= 16'd0;
            errc_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prio_q  <= prio_d;
            addr_q  <= addr_d;
            op_q    <= op_d;
            gid_q   <= gid_d;
            r0c_q   <= r0c_d;
            r1c_q   <= r1c_d;
            errc_q  <= errc_d;
        end
    end

    assign r0_ready    = accept && !sel;
    assign r1_ready    = accept &&  sel;
    assign issue_valid = (state_q == S_ISSUE);
    assign busy        = (state_q != S_IDLE);
    assign cache_addr  = addr_q;
    assign cache_op    = op_q;
    assign grant_id    = gid_q;
    assign r0_count    = r0c_q;
    assign r1_count    = r1c_q;
    assign err_count   = errc_q;

endmodule

// File: tb/tb_cache_req_sched.sv
// Bench for cache_req_sched: directed scenarios followed by random traffic,
// all checked against a cycle-timestamp model (busy windows, tie pointer,
// saturating tallies).
module tb_cache_req_sched;

    localparam int AW = 48;
    localparam int B  = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          sched_en;
    logic          r0_valid, r1_valid;
    logic [AW-1:0] r0_addr, r1_addr;
    logic [7:0]    r0_op, r1_op;
    logic          r0_ready, r1_ready;
    logic [AW-1:0] cache_addr;
    logic [7:0]    cache_op;
    logic          issue_valid, grant_id, busy;
    logic [15:0]   r0_count, r1_count, err_count;

    cache_req_sched #(.ADDR_W(AW), .BUSY_CYCLES(B)) dut (
        .clk(clk), .reset(reset), .sched_en(sched_en),
        .r0_valid(r0_valid), .r1_valid(r1_valid),
        .r0_addr(r0_addr), .r1_addr(r1_addr),
        .r0_op(r0_op), .r1_op(r1_op),
        .r0_ready(r0_ready), .r1_ready(r1_ready),
        .cache_addr(cache_addr), .cache_op(cache_op),
        .issue_valid(issue_valid), .grant_id(grant_id), .busy(busy),
        .r0_count(r0_count), .r1_count(r1_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: time-stamped view of the scheduler.
    int            t;          // current cycle index
    int            issue_at;   // cycle in which the strobe is expected
    int            free_at;    // first cycle the scheduler is idle again
    bit            prio;       // requester favoured on a tie
    logic [AW-1:0] m_addr;
    logic [7:0]    m_op;
    bit            m_gid;
    int            c0, c1, ce;
    bit            m_r0, m_r1;

    function automatic int sat(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
        end
    endtask

    task automatic model_reset();
        issue_at = -1; free_at = 0; prio = 1'b0;
        m_addr = '0; m_op = 8'd0; m_gid = 1'b0;
        c0 = 0; c1 = 0; ce = 0;
    endtask

    task automatic chk_state();
        chk("issue_valid", 64'(issue_valid), 64'(t == issue_at));
        chk("busy",        64'(busy),        64'(t < free_at));
        chk("cache_addr",  64'(cache_addr),  64'(m_addr));
        chk("cache_op",    64'(cache_op),    64'(m_op));
        chk("grant_id",    64'(grant_id),    64'(m_gid));
        chk("r0_count",    64'(r0_count),    64'(c0));
        chk("r1_count",    64'(r1_count),    64'(c1));
        chk("err_count",   64'(err_count),   64'(ce));
    endtask

    task automatic step(input bit en, input bit v0, input bit v1,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [7:0] o0, input logic [7:0] o1);
        bit acc, sel;
        logic [7:0] sop;
        @(negedge clk);
        sched_en = en; r0_valid = v0; r1_valid = v1;
        r0_addr = a0; r1_addr = a1; r0_op = o0; r1_op = o1;
        #1;
        acc  = (t >= free_at) && en && (v0 || v1);
        sel  = (v0 && v1) ? prio : !v0;
        m_r0 = acc && !sel;
        m_r1 = acc && sel;
        chk("r0_ready", 64'(r0_ready), 64'(m_r0));
        chk("r1_ready", 64'(r1_ready), 64'(m_r1));
        chk_state();
        // effects of the coming edge
        if (t == issue_at) begin
            if (m_gid) c1 = sat(c1); else c0 = sat(c0);
        end
        if (acc) begin
            prio = !sel;
            sop  = sel ? o1 : o0;
            if (sop == 8'h52 || sop == 8'h57) begin
                m_addr   = sel ? a1 : a0;
                m_op     = sop;
                m_gid    = sel;
                issue_at = t + 1;
                free_at  = t + 2 + B;
            end else begin
                ce = sat(ce);
            end
        end
        t++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, '0, '0, 8'h52, 8'h52);
    endtask

    // Asserted mid-cycle so the async path is observed before any edge.
    task automatic do_reset();
        @(negedge clk);
        r0_valid = 1'b0; r1_valid = 1'b0;
        reset = 1'b0;
        #1;
        model_reset();
        chk("rst_r0_ready", 64'(r0_ready), 64'd0);
        chk("rst_r1_ready", 64'(r1_ready), 64'd0);
        chk_state();
        @(posedge clk);
        #2 reset = 1'b1;
        t++;
    endtask

    bit            p0v, p1v;
    logic [AW-1:0] p0a, p1a;
    logic [7:0]    p0o, p1o;

    function automatic logic [7:0] rand_op();
        int r;
        r = int'($urandom_range(0, 7));
        if (r == 0) return 8'($urandom);
        return (r % 2 != 0) ? 8'h52 : 8'h57;
    endfunction

    initial begin
        t = 0;
        model_reset();
        reset = 1'b0; sched_en = 1'b0;
        r0_valid = 1'b0; r1_valid = 1'b0;
        r0_addr = '0; r1_addr = '0; r0_op = 8'd0; r1_op = 8'd0;
        do_reset();

        // single read from r0
        step(1'b1, 1'b1, 1'b0, 48'h1000, '0, 8'h52, 8'h52);
        idle(5);

        // both requesters held valid: alternating grants
        for (int i = 0; i < 12; i++)
            step(1'b1, 1'b1, 1'b1, 48'hA0A0, 48'hB0B0, 8'h52, 8'h57);
        idle(4);

        // illegal op from r1, then a tie
        step(1'b1, 1'b0, 1'b1, '0, 48'h2000, 8'h52, 8'h41);
        for (int i = 0; i < 6; i++)
            step(1'b1, 1'b1, 1'b1, 48'h3000, 48'h4000, 8'h57, 8'h52);
        idle(4);

        // sched_en dropped in the ISSUE cycle
        step(1'b1, 1'b1, 1'b0, 48'h5000, '0, 8'h57, 8'h52);
        for (int i = 0; i < 6; i++)
            step(1'b0, 1'b1, 1'b1, 48'h6000, 48'h7000, 8'h52, 8'h52);
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b1, 1'b1, 48'h6000, 48'h7000, 8'h52, 8'h52);
        idle(4);

        // reset in WAIT, then r0 favoured again
        step(1'b1, 1'b0, 1'b1, '0, 48'h8000, 8'h52, 8'h57);
        step(1'b1, 1'b0, 1'b0, '0, '0, 8'h52, 8'h52);
        step(1'b1, 1'b0, 1'b0, '0, '0, 8'h52, 8'h52);
        do_reset();
        for (int i = 0; i < 6; i++)
            step(1'b1, 1'b1, 1'b1, 48'h9000, 48'h9100, 8'h52, 8'h52);
        idle(4);

        // random traffic; requests held until accepted
        p0v = 1'b0; p1v = 1'b0;
        p0a = '0; p1a = '0; p0o = 8'h52; p1o = 8'h52;
        for (int i = 0; i < 3000; i++) begin
            if (!p0v && $urandom_range(0, 2) == 0) begin
                p0v = 1'b1; p0a = {16'($urandom), 32'($urandom)}; p0o = rand_op();
            end
            if (!p1v && $urandom_range(0, 2) == 0) begin
                p1v = 1'b1; p1a = {16'($urandom), 32'($urandom)}; p1o = rand_op();
            end
            step($urandom_range(0, 7) != 0, p0v, p1v, p0a, p1a, p0o, p1o);
            if (m_r0) p0v = 1'b0;
            if (m_r1) p1v = 1'b0;
            if (i == 1500) do_reset();
        end
        idle(4);

        // err_count saturation: illegal ops are accepted every cycle
        for (int i = 0; i < 65540; i++)
            step(1'b1, 1'b1, 1'b0, 48'h1, '0, 8'h00, 8'h52);
        chk("err_count_sat", 64'(err_count), 64'hFFFF);
        step(1'b1, 1'b1, 1'b0, 48'hC000, '0, 8'h52, 8'h52);
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
